axis_pkt_rr_arbiter: RTL and testbench

//  Shares one Nanotube pipeline ingress (port0) between two AXI-Stream packet sources.

---
 rtl/nanotube_axis_pkg.sv | 31 +++
 rtl/axis_skid_buf.sv | 75 +++++++
 rtl/axis_pkt_rr_arbiter.sv | 107 ++++++++++
 tb/tb_axis_pkt_rr_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nanotube_axis_pkg.sv
// Shared AXI-Stream widths, beat layout and arbiter state encoding for the
// Nanotube ingress path.
package nanotube_axis_pkg;

    localparam int AXIS_DATA_W = 512;
    localparam int AXIS_USER_W = 48;
    localparam int AXIS_KEEP_W = AXIS_DATA_W / 8;

    typedef struct packed {
        logic [AXIS_DATA_W-1:0] tdata;
        logic [AXIS_KEEP_W-1:0] tkeep;
        logic [AXIS_USER_W-1:0] tuser;
        logic                   tlast;
    } axis_beat_t;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    // Round-robin pick between two requesters; only meaningful when at least
    // one of them is valid. The source that did not go last wins if it asks.
    function automatic logic rr_pick(input logic last_grant,
                                     input logic v0,
                                     input logic v1);
        logic other_valid;
        other_valid = last_grant ? v0 : v1;
        return other_valid ? ~last_grant : last_grant;
    endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry registered skid buffer: output is always driven from the head
// register, so downstream sees a fully registered AXI-Stream interface.
module axis_skid_buf
    import nanotube_axis_pkg::*;
#(
    parameter int W = AXIS_DATA_W + AXIS_KEEP_W + AXIS_USER_W + 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] in_data_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    output logic [W-1:0] out_data_o,
    output logic         out_valid_o,
    input  logic         out_ready_i
);

    logic [1:0]   count_q, count_d;
    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    logic         push, pop;

    assign in_ready_o  = (count_q != 2'd2);
    assign out_valid_o = (count_q != 2'd0);
    assign out_data_o  = head_q;

    assign push = in_valid_i & in_ready_o;
    assign pop  = out_valid_o & out_ready_i;

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_d = in_data_i;
                end else begin
                    tail_d = in_data_i;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                // Occupancy is unchanged; the new beat lands wherever the
                // departing head leaves a gap.
                if (count_q == 2'd1) begin
                    head_d = in_data_i;
                end else begin
                    head_d = tail_q;
                    tail_d = in_data_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= 2'd0;
            head_q  <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
        end
    end

    always_ff @(posedge clk_i) begin
        tail_q <= tail_d;
    end

endmodule

// File: rtl/axis_pkt_rr_arbiter.sv
// Packet-granular round-robin arbiter merging two AXI-Stream sources onto
// Nanotube pipeline port0 through a registered skid buffer.
module axis_pkt_rr_arbiter
    import nanotube_axis_pkg::*;
#(
    parameter int DATA_W = AXIS_DATA_W,
    parameter int USER_W = AXIS_USER_W,
    parameter int CNT_W  = 32
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic [DATA_W-1:0]     s0_tdata,
    input  logic [DATA_W/8-1:0]   s0_tkeep,
    input  logic [USER_W-1:0]     s0_tuser,
    input  logic                  s0_tlast,
    input  logic                  s0_tvalid,
    output logic                  s0_tready,
    input  logic [DATA_W-1:0]     s1_tdata,
    input  logic [DATA_W/8-1:0]   s1_tkeep,
    input  logic [USER_W-1:0]     s1_tuser,
    input  logic                  s1_tlast,
    input  logic                  s1_tvalid,
    output logic                  s1_tready,
    output logic [DATA_W-1:0]     m_tdata,
    output logic [DATA_W/8-1:0]   m_tkeep,
    output logic [USER_W-1:0]     m_tuser,
    output logic                  m_tlast,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  grant,
    output logic                  busy,
    output logic [CNT_W-1:0]      pkt_cnt0,
    output logic [CNT_W-1:0]      pkt_cnt1
);

    localparam int KEEP_W = DATA_W / 8;
    localparam int BEAT_W = DATA_W + KEEP_W + USER_W + 1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    arb_state_t         state_q;
    logic               grant_q;
    logic [CNT_W-1:0]   cnt0_q, cnt1_q;

    logic               skid_ready;
    logic               sel_valid, sel_last, accept, locked;
    logic [BEAT_W-1:0]  sel_beat, head_beat;

    assign locked    = (state_q == ARB_BUSY);
    assign sel_valid = grant_q ? s1_tvalid : s0_tvalid;
    assign sel_last  = grant_q ? s1_tlast  : s0_tlast;
    assign sel_beat  = grant_q ? {s1_tdata, s1_tkeep, s1_tuser, s1_tlast}
                               : {s0_tdata, s0_tkeep, s0_tuser, s0_tlast};
    assign accept    = locked & sel_valid & skid_ready;

    // Only the locked source ever sees ready; the IDLE decision cycle is a bubble.
    assign s0_tready = locked & ~grant_q & skid_ready;
    assign s1_tready = locked &  grant_q & skid_ready;

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q <= ARB_IDLE;
            grant_q <= 1'b1;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (s0_tvalid | s1_tvalid) begin
                        state_q <= ARB_BUSY;
                        grant_q <= rr_pick(grant_q, s0_tvalid, s1_tvalid);
                    end
                end
                ARB_BUSY: begin
                    if (accept && sel_last) begin
                        state_q <= ARB_IDLE;
                        if (grant_q) begin
                            cnt1_q <= cnt1_q + CNT_ONE;
                        end else begin
                            cnt0_q <= cnt0_q + CNT_ONE;
                        end
                    end
                end
            endcase
        end
    end

    axis_skid_buf #(
        .W (BEAT_W)
    ) u_skid (
        .clk_i       (ap_clk),
        .rst_ni      (ap_rst_n),
        .in_data_i   (sel_beat),
        .in_valid_i  (locked & sel_valid),
        .in_ready_o  (skid_ready),
        .out_data_o  (head_beat),
        .out_valid_o (m_tvalid),
        .out_ready_i (m_tready)
    );

    assign {m_tdata, m_tkeep, m_tuser, m_tlast} = head_beat;

    assign grant    = grant_q;
    assign busy     = locked;
    assign pkt_cnt0 = cnt0_q;
    assign pkt_cnt1 = cnt1_q;

endmodule

// File: tb/tb_axis_pkt_rr_arbiter.sv
// Randomised bench for axis_pkt_rr_arbiter: queue-based reference model of the
// arbitration rules and output buffering, plus directed corner scenarios.
module tb_axis_pkt_rr_arbiter;
    import nanotube_axis_pkg::*;

    localparam int DW = AXIS_DATA_W;
    localparam int KW = AXIS_KEEP_W;
    localparam int UW = AXIS_USER_W;

    logic ap_clk = 1'b0;
    logic ap_rst_n = 1'b0;
    always #5 ap_clk = ~ap_clk;

    logic [DW-1:0] s0_tdata = '0, s1_tdata = '0;
    logic [KW-1:0] s0_tkeep = '0, s1_tkeep = '0;
    logic [UW-1:0] s0_tuser = '0, s1_tuser = '0;
    logic          s0_tlast = 1'b0, s1_tlast = 1'b0;
    logic          s0_tvalid = 1'b0, s1_tvalid = 1'b0;
    logic          s0_tready, s1_tready;
    logic          m_tready = 1'b1;

    logic [DW-1:0] m_tdata, m2_tdata;
    logic [KW-1:0] m_tkeep, m2_tkeep;
    logic [UW-1:0] m_tuser, m2_tuser;
    logic          m_tlast, m2_tlast, m_tvalid, m2_tvalid;
    logic          s0_tready2, s1_tready2;
    logic          grant, busy, grant2, busy2;
    logic [31:0]   pkt_cnt0, pkt_cnt1;
    logic [1:0]    c2_0, c2_1;

    axis_pkt_rr_arbiter dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .s0_tdata(s0_tdata), .s0_tkeep(s0_tkeep), .s0_tuser(s0_tuser),
        .s0_tlast(s0_tlast), .s0_tvalid(s0_tvalid), .s0_tready(s0_tready),
        .s1_tdata(s1_tdata), .s1_tkeep(s1_tkeep), .s1_tuser(s1_tuser),
        .s1_tlast(s1_tlast), .s1_tvalid(s1_tvalid), .s1_tready(s1_tready),
        .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tuser(m_tuser),
        .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .grant(grant), .busy(busy), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
    );

    // Narrow-counter twin on the same stimulus, so counter wrap is reachable.
    axis_pkt_rr_arbiter #(.CNT_W(2)) dut_w2 (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .s0_tdata(s0_tdata), .s0_tkeep(s0_tkeep), .s0_tuser(s0_tuser),
        .s0_tlast(s0_tlast), .s0_tvalid(s0_tvalid), .s0_tready(s0_tready2),
        .s1_tdata(s1_tdata), .s1_tkeep(s1_tkeep), .s1_tuser(s1_tuser),
        .s1_tlast(s1_tlast), .s1_tvalid(s1_tvalid), .s1_tready(s1_tready2),
        .m_tdata(m2_tdata), .m_tkeep(m2_tkeep), .m_tuser(m2_tuser),
        .m_tlast(m2_tlast), .m_tvalid(m2_tvalid), .m_tready(m_tready),
        .grant(grant2), .busy(busy2), .pkt_cnt0(c2_0), .pkt_cnt1(c2_1)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    axis_beat_t  mq[$];
    bit          busy_m = 1'b0, grant_m = 1'b1, acc0 = 1'b0, acc1 = 1'b0, saw_full = 1'b0;
    int unsigned cnt_m0 = 0, cnt_m1 = 0, beats_m1 = 0, cyc = 0;

    always @(posedge ap_clk) begin
        int sz;
        cyc++;
        if (!ap_rst_n) begin
            mq.delete();
            busy_m = 1'b0; grant_m = 1'b1; acc0 = 1'b0; acc1 = 1'b0;
            cnt_m0 = 0; cnt_m1 = 0;
        end else begin
            sz   = mq.size();
            acc0 = busy_m && !grant_m && s0_tvalid && sz < 2;
            acc1 = busy_m &&  grant_m && s1_tvalid && sz < 2;
            if (sz > 0 && m_tready) void'(mq.pop_front());
            if (acc0) mq.push_back('{s0_tdata, s0_tkeep, s0_tuser, s0_tlast});
            if (acc1) begin
                mq.push_back('{s1_tdata, s1_tkeep, s1_tuser, s1_tlast});
                beats_m1++;
            end
            if (mq.size() == 2) saw_full = 1'b1;
            if (!busy_m) begin
                if (s0_tvalid || s1_tvalid) begin
                    if (grant_m ? s0_tvalid : s1_tvalid) grant_m = !grant_m;
                    busy_m = 1'b1;
                end
            end else if ((acc0 && s0_tlast) || (acc1 && s1_tlast)) begin
                busy_m = 1'b0;
                if (grant_m) cnt_m1++; else cnt_m0++;
            end
        end
    end

    // ---------------- source / sink drivers ----------------
    axis_beat_t q0[$], q1[$];
    bit pres0 = 1'b0, pres1 = 1'b0;
    int vprob0 = 100, vprob1 = 100, rdy_mode = 0;

    always @(posedge ap_clk) begin
        #1;
        if (pres0 && acc0) begin void'(q0.pop_front()); pres0 = 1'b0; end
        if (pres1 && acc1) begin void'(q1.pop_front()); pres1 = 1'b0; end
        if (!pres0 && q0.size() > 0 && $urandom_range(99) < vprob0) pres0 = 1'b1;
        if (!pres1 && q1.size() > 0 && $urandom_range(99) < vprob1) pres1 = 1'b1;
        s0_tvalid = pres0;
        s1_tvalid = pres1;
        if (q0.size() > 0) {s0_tdata, s0_tkeep, s0_tuser, s0_tlast} = q0[0];
        if (q1.size() > 0) {s1_tdata, s1_tkeep, s1_tuser, s1_tlast} = q1[0];
        case (rdy_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = !m_tready;
            default: m_tready = 1'($urandom_range(1));
        endcase
    end

    // ---------------- per-cycle comparison ----------------
    bit chk_en = 1'b0;
    bit in_pkt = 1'b0;
    bit order_q[$];

    always @(negedge ap_clk) begin
        bit v;
        if (chk_en) begin
            v = (mq.size() > 0);
            chk("m_tvalid", m_tvalid, v);
            chk("m_tvalid_w2", m2_tvalid, v);
            if (v) begin
                chk("m_tdata", m_tdata, mq[0].tdata);
                chk("m_tkeep", m_tkeep, mq[0].tkeep);
                chk("m_tuser", m_tuser, mq[0].tuser);
                chk("m_tlast", m_tlast, mq[0].tlast);
                chk("m_beat_w2", {m2_tdata, m2_tkeep, m2_tuser, m2_tlast},
                    {mq[0].tdata, mq[0].tkeep, mq[0].tuser, mq[0].tlast});
            end
            chk("s0_tready", s0_tready, busy_m && !grant_m && mq.size() < 2);
            chk("s1_tready", s1_tready, busy_m &&  grant_m && mq.size() < 2);
            chk("tready_w2", {s0_tready2, s1_tready2}, {s0_tready, s1_tready});
            chk("busy", busy, busy_m);
            chk("grant", grant, grant_m);
            chk("busy_grant_w2", {busy2, grant2}, {busy_m, grant_m});
            chk("pkt_cnt0", pkt_cnt0, cnt_m0);
            chk("pkt_cnt1", pkt_cnt1, cnt_m1);
            chk("pkt_cnt0_w2", c2_0, cnt_m0 % 4);
            chk("pkt_cnt1_w2", c2_1, cnt_m1 % 4);
            if (m_tvalid && m_tready) begin
                if (!in_pkt) order_q.push_back(m_tuser[UW-1]);
                in_pkt = !m_tlast;
            end
        end
    end

    function automatic axis_beat_t mk_beat(input bit src, input bit last);
        axis_beat_t b;
        logic [KW-1:0] k;
        for (int i = 0; i < DW / 32; i++) b.tdata[i*32 +: 32] = $urandom;
        k       = '1;
        b.tkeep = last ? (k >> $urandom_range(KW - 1)) : k;
        b.tuser = {src, 47'($urandom)};
        b.tlast = last;
        return b;
    endfunction

    task automatic push_pkt(input bit src, input int len);
        for (int i = 0; i < len; i++) begin
            if (src) q1.push_back(mk_beat(1'b1, i == len - 1));
            else     q0.push_back(mk_beat(1'b0, i == len - 1));
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (!(q0.size() == 0 && q1.size() == 0 && !pres0 && !pres1 &&
                 mq.size() == 0 && !busy_m) && n < 3000) begin
            @(negedge ap_clk);
            n++;
        end
        chk({tag, "_drained"}, n < 3000, 1);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        axis_beat_t b;
        int t_v, t_m, viol, n;

        // Reset held for five edges.
        ap_rst_n = 1'b0;
        repeat (5) @(negedge ap_clk);
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_m_beat", {m_tdata, m_tkeep, m_tuser, m_tlast}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant, 1);
        chk("rst_treadys", {s0_tready, s1_tready}, 0);
        chk("rst_cnts", {pkt_cnt0, pkt_cnt1}, 0);
        chk_en   = 1'b1;
        ap_rst_n = 1'b1;

        // Directed 2-beat packet from s0 and its latency.
        b.tdata = {16{32'hA5A5_0001}}; b.tkeep = '1; b.tuser = 48'h62; b.tlast = 1'b0;
        q0.push_back(b);
        b.tdata = {16{32'h5A5A_0002}}; b.tkeep = 64'h0000_0003_FFFF_FFFF; b.tlast = 1'b1;
        q0.push_back(b);
        t_v = -1; t_m = -1;
        for (int i = 0; i < 20 && t_m < 0; i++) begin
            @(negedge ap_clk);
            if (s0_tvalid && t_v < 0) t_v = int'(cyc);
            if (m_tvalid) t_m = int'(cyc);
        end
        chk("first_beat_latency", t_m - t_v, 2);
        chk("first_beat_keep", m_tkeep, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_idle("directed");
        chk("cnt0_after_directed", pkt_cnt0, 1);

        // Both sources continuously valid: strict alternation.
        order_q.delete();
        for (int i = 0; i < 4; i++) begin push_pkt(1'b0, 2); push_pkt(1'b1, 2); end
        wait_idle("alternate");
        chk("alt_pkt_count", order_q.size(), 8);
        if (order_q.size() > 0) chk("alt_first_src", order_q[0], 1);
        viol = 0;
        for (int i = 1; i < order_q.size(); i++) if (order_q[i] == order_q[i-1]) viol++;
        chk("alt_violations", viol, 0);

        // m_tready toggling every cycle fills the skid buffer.
        rdy_mode = 1; saw_full = 1'b0;
        for (int i = 0; i < 2; i++) begin push_pkt(1'b0, 3); push_pkt(1'b1, 3); end
        wait_idle("toggle");
        chk("skid_full_seen", saw_full, 1);
        rdy_mode = 0;

        // s1 stalls mid-packet while s0 waits.
        n = int'(beats_m1);
        q1.push_back(mk_beat(1'b1, 1'b0));
        push_pkt(1'b0, 2);
        for (int i = 0; i < 20 && int'(beats_m1) == n; i++) @(negedge ap_clk);
        chk("stall_first_s1_beat", int'(beats_m1) - n, 1);
        viol = 0;
        repeat (3) begin
            @(negedge ap_clk);
            if (s0_tready) viol++;
        end
        chk("stall_s1_tvalid_low", s1_tvalid, 0);
        n = int'(cnt_m1);
        q1.push_back(mk_beat(1'b1, 1'b0));
        q1.push_back(mk_beat(1'b1, 1'b1));
        for (int i = 0; i < 20 && int'(cnt_m1) == n; i++) begin
            @(negedge ap_clk);
            if (s0_tready && int'(cnt_m1) == n) viol++;
        end
        chk("stall_s0_held_off", viol, 0);
        wait_idle("stall");

        // Narrow counter wraps 3 -> 0.
        for (int i = 0; i < 8 && (cnt_m0 % 4) != 3; i++) begin
            push_pkt(1'b0, 1);
            wait_idle("prewrap");
        end
        chk("w2_cnt0_before_wrap", c2_0, 3);
        push_pkt(1'b0, 1);
        wait_idle("wrap");
        chk("w2_cnt0_wrapped", c2_0, 0);

        // Reset in the middle of a packet.
        push_pkt(1'b1, 4);
        for (int i = 0; i < 20 && !m_tvalid; i++) @(negedge ap_clk);
        chk("midrst_pre_cnt_nonzero", (pkt_cnt0 != 0), 1);
        q0.delete(); q1.delete(); pres0 = 1'b0; pres1 = 1'b0; in_pkt = 1'b0;
        ap_rst_n = 1'b0;
        @(negedge ap_clk);
        chk("midrst_m_tvalid", m_tvalid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_cnts", {pkt_cnt0, pkt_cnt1}, 0);
        chk("midrst_grant", grant, 1);
        ap_rst_n = 1'b1;

        // Randomised traffic with random backpressure and valid gaps.
        rdy_mode = 2;
        for (int i = 0; i < 1500; i++) begin
            @(negedge ap_clk);
            if (i % 100 == 0) begin
                vprob0 = $urandom_range(100, 40);
                vprob1 = $urandom_range(100, 40);
            end
            if (q0.size() < 4 && $urandom_range(9) == 0) push_pkt(1'b0, $urandom_range(4, 1));
            if (q1.size() < 4 && $urandom_range(9) == 0) push_pkt(1'b1, $urandom_range(4, 1));
        end
        vprob0 = 100; vprob1 = 100; rdy_mode = 0;
        wait_idle("random");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
